// File: rtl/spill_register_chain_pkg.sv
// Shared helpers for the spill register chain.
// The occupancy width is derived from the stage count so callers never size it by hand.
package spill_register_chain_pkg;

    // Smallest counter able to hold 0..2*num_stages, never narrower than one bit.
    function automatic int spill_cnt_width(input int num_stages);
        int w;
        w = $clog2(2 * num_stages + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spill_register_chain_stage.sv
// One two-slot spill stage: slot A takes the upstream beat, slot B catches it when
// downstream stalls, so no valid, data or ready path passes straight through.
module spill_register_chain_stage #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o
);

    logic                 r_a_full;
    logic                 r_b_full;
    logic [DataWidth-1:0] r_a_data;
    logic [DataWidth-1:0] r_b_data;

    logic w_ready;
    logic w_a_fill;
    logic w_a_drain;
    logic w_b_fill;
    logic w_b_drain;

    assign w_ready   = ~r_a_full | ~r_b_full;
    assign w_a_fill  = valid_i & ready_o;
    assign w_a_drain = r_a_full & ~r_b_full;
    assign w_b_fill  = w_a_drain & ~ready_i;
    assign w_b_drain = r_b_full & ready_i;

    // Flush masks both handshake signals so nothing completes in the clearing cycle.
    assign ready_o = w_ready & ~flush_i;
    assign valid_o = (r_a_full | r_b_full) & ~flush_i;
    assign data_o  = r_b_full ? r_b_data : r_a_data;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
        end else begin
            r_a_full <= w_a_fill | (r_a_full & ~w_a_drain);
            r_b_full <= w_b_fill | (r_b_full & ~w_b_drain);
        end
    end

    // Payload registers carry no reset; the full flags alone qualify them.
    always_ff @(posedge clk_i) begin
        if (w_a_fill) begin
            r_a_data <= data_i;
        end
        if (w_b_fill) begin
            r_b_data <= r_a_data;
        end
    end

endmodule

// File: rtl/spill_register_chain.sv
// Flushable cascade of spill stages with an occupancy counter; NumStages=0 is a
// plain wire-through with no state.
module spill_register_chain
    import spill_register_chain_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumStages = 1,
    parameter int CntWidth  = spill_cnt_width(NumStages)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntWidth-1:0]  occupancy_o
);

    if (NumStages > 0) begin : g_chain
        logic                 w_valid [NumStages+1];
        logic                 w_ready [NumStages+1];
        logic [DataWidth-1:0] w_data  [NumStages+1];
        logic                 w_up;
        logic                 w_dn;
        logic [CntWidth-1:0]  r_occ;

        assign w_valid[0]         = valid_i;
        assign w_data[0]          = data_i;
        assign ready_o            = w_ready[0];
        assign valid_o            = w_valid[NumStages];
        assign data_o             = w_data[NumStages];
        assign w_ready[NumStages] = ready_i;

        for (genvar k = 0; k < NumStages; k++) begin : g_stage
            spill_register_chain_stage #(
                .DataWidth (DataWidth)
            ) u_stage (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .flush_i (flush_i),
                .valid_i (w_valid[k]),
                .ready_o (w_ready[k]),
                .data_i  (w_data[k]),
                .valid_o (w_valid[k+1]),
                .ready_i (w_ready[k+1]),
                .data_o  (w_data[k+1])
            );
        end

        // Tracks beats in flight from the endpoint handshakes, mirroring the sum of full flags.
        assign w_up = valid_i & ready_o;
        assign w_dn = valid_o & ready_i;

        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_occ <= '0;
            end else if (w_up && !w_dn) begin
                r_occ <= r_occ + CntWidth'(1);
            end else if (w_dn && !w_up) begin
                r_occ <= r_occ - CntWidth'(1);
            end
        end

        assign occupancy_o = r_occ;

`ifndef SYNTHESIS
        a_data_stable : assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_o && !ready_i) |=> (flush_i || $stable(data_o)));
        a_valid_hold : assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_o && !ready_i) |=> (valid_o || flush_i));
        a_occ_bound : assert property (@(posedge clk_i) disable iff (rst_i)
            int'(occupancy_o) <= 2 * NumStages);
`endif
    end else begin : g_bypass
        logic w_unused;

        assign ready_o     = ready_i;
        assign valid_o     = valid_i;
        assign data_o      = data_i;
        assign occupancy_o = '0;
        assign w_unused    = clk_i ^ rst_i ^ flush_i;
    end

endmodule
